// File: rtl/commit_monitor_pkg.sv
// Shared types and constants for the retirement-stream monitor.
// State encoding, the ebreak opcode and the default reset PC.
package commit_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/commit_watchdog.sv
// Commit-free cycle counter for the retirement monitor.
// Ports: clk, rst (async, active high), clr (sync), active (monitor in
// IDLE/RUN), accept (a commit is taken this cycle), expire (hang pulse).
module commit_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic active,
  input  logic accept,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The cycle whose edge would make the count reach TIMEOUT_CYC is the
  // expiry cycle; a commit in that same cycle cancels it.
  assign expire = active && !accept && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || accept || !active) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Passive checker of the core's retirement stream: PC continuity, cycle
// and instruction counts, ebreak end-of-test, optional hang detection.
// Inputs: clk, rst (async, active high), clr (sync), commit, commit_pc,
// commit_pre_pc, commit_instr. Outputs: state, cycle_cnt, instr_cnt,
// mismatch, timeout, err_pc, err_expect (all registered).
// Build option: define COMMIT_MONITOR_WATCHDOG_EN for the hang watchdog.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             commit,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_pre_pc,
  input  logic [31:0]      commit_instr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             mismatch,
  output logic             timeout,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_expect
);

  state_e           state_q, state_d;
  logic [31:0]      exp_pc_q, exp_pc_d;
  logic [31:0]      err_pc_q, err_pc_d;
  logic [31:0]      err_expect_q, err_expect_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             timeout_q, timeout_d;

  logic active;
  logic accept;
  logic pc_ok;
  logic is_ebreak;
  logic wd_expire;

  assign active    = (state_q == ST_IDLE) || (state_q == ST_RUN);
  // A commit in a clr cycle is discarded.
  assign accept    = commit && active && !clr;
  assign pc_ok     = (commit_pc == exp_pc_q);
  assign is_ebreak = (commit_instr == INSTR_EBREAK);

`ifdef COMMIT_MONITOR_WATCHDOG_EN
  commit_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .active(active),
    .accept(accept),
    .expire(wd_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    exp_pc_d     = exp_pc_q;
    err_pc_d     = err_pc_q;
    err_expect_d = err_expect_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    mismatch_d   = mismatch_q;
    timeout_d    = timeout_q;

    if (clr) begin
      state_d      = ST_IDLE;
      exp_pc_d     = RESET_PC;
      err_pc_d     = '0;
      err_expect_d = '0;
      cycle_cnt_d  = '0;
      instr_cnt_d  = '0;
      mismatch_d   = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      // Counts the cycle spent in RUN, including the one that halts.
      if (state_q == ST_RUN && cycle_cnt_q != '1) begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end

      if (accept) begin
        // PC check takes precedence over ebreak detection.
        if (pc_ok) begin
          if (instr_cnt_q != '1) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
          end
          exp_pc_d = commit_pre_pc;
          state_d  = is_ebreak ? ST_HALT : ST_RUN;
        end else begin
          mismatch_d   = 1'b1;
          err_pc_d     = commit_pc;
          err_expect_d = exp_pc_q;
          state_d      = ST_ERROR;
        end
      end else if (wd_expire) begin
        timeout_d    = 1'b1;
        err_pc_d     = '0;
        err_expect_d = exp_pc_q;
        state_d      = ST_ERROR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      exp_pc_q     <= RESET_PC;
      err_pc_q     <= '0;
      err_expect_q <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_pc_q     <= exp_pc_d;
      err_pc_q     <= err_pc_d;
      err_expect_q <= err_expect_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      mismatch_q   <= mismatch_d;
      timeout_q    <= timeout_d;
    end
  end

  assign state      = state_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign mismatch   = mismatch_q;
  assign timeout    = timeout_q;
  assign err_pc     = err_pc_q;
  assign err_expect = err_expect_q;

endmodule
